gcd_rr_scheduler: RTL and testbench

//  Shares one GCD engine (valid/ready A, B operand channels; valid/ready result) among NREQ requesters.
//  - Round-robin arbitration; one operation in flight at a time.
//  - Captures the winning operand pair, issues it on the engine's A/B channels, collects the result and returns it to the granted requester.
//  - Sits between client blocks and the single GCD datapath instance.

---
 rtl/gcd_rr_scheduler_if.sv | 45 ++++
 rtl/gcd_rr_scheduler.sv | 118 +++++++++++
 tb/tb_gcd_rr_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_rr_scheduler_if.sv
// Requester, response and engine handshake bundle for gcd_rr_scheduler.
// The scheduler uses the slave modport; the surrounding system uses the master modport.
interface gcd_rr_scheduler_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = 16
);
  localparam int unsigned GW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [DW-1:0]      rsp_data;
  logic [DW-1:0]      eng_a_data;
  logic               eng_a_valid;
  logic               eng_a_ready;
  logic [DW-1:0]      eng_b_data;
  logic               eng_b_valid;
  logic               eng_b_ready;
  logic [DW-1:0]      eng_gcd_data;
  logic               eng_gcd_valid;
  logic               eng_gcd_ready;
  logic               busy;
  logic [GW-1:0]      grant_id;
  logic [CW-1:0]      op_count;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    input  eng_a_ready, eng_b_ready, eng_gcd_data, eng_gcd_valid,
    output req_ready, rsp_valid, rsp_data,
    output eng_a_data, eng_a_valid, eng_b_data, eng_b_valid, eng_gcd_ready,
    output busy, grant_id, op_count
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    output eng_a_ready, eng_b_ready, eng_gcd_data, eng_gcd_valid,
    input  req_ready, rsp_valid, rsp_data,
    input  eng_a_data, eng_a_valid, eng_b_data, eng_b_valid, eng_gcd_ready,
    input  busy, grant_id, op_count
  );
endinterface

// File: rtl/gcd_rr_scheduler.sv
// Round-robin scheduler sharing one GCD engine among NREQ requesters, one op in flight.
// Define GCD_SCHED_PERF_EN to enable the saturating op_count completion counter.
module gcd_rr_scheduler #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = 16
) (
  input logic               clk,
  input logic               rst_n,
  gcd_rr_scheduler_if.slave bus
);
  localparam int unsigned GW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e        state;
  logic [GW-1:0] ptr;
  logic [GW-1:0] winner;
  logic          found;
  logic          a_done;
  logic          b_done;
  logic          rsp_hs;

  // First requesting index at or after the pointer, wrapping NREQ-1 -> 0.
  always_comb begin
    int unsigned   idx;
    logic [GW-1:0] cand;
    idx    = 0;
    cand   = '0;
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx  = (32'(ptr) + k) % NREQ;
      cand = GW'(idx);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (rst_n && state == StIdle && found) bus.req_ready[winner] = 1'b1;
  end

  // A channel is done once its valid has dropped or is being accepted this cycle.
  assign a_done = !bus.eng_a_valid || bus.eng_a_ready;
  assign b_done = !bus.eng_b_valid || bus.eng_b_ready;
  assign rsp_hs = bus.rsp_ready[bus.grant_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= StIdle;
      ptr               <= '0;
      bus.grant_id      <= '0;
      bus.busy          <= 1'b0;
      bus.eng_a_data    <= '0;
      bus.eng_b_data    <= '0;
      bus.eng_a_valid   <= 1'b0;
      bus.eng_b_valid   <= 1'b0;
      bus.eng_gcd_ready <= 1'b0;
      bus.rsp_valid     <= '0;
      bus.rsp_data      <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (found) begin
            bus.eng_a_data  <= bus.req_a[winner*DW +: DW];
            bus.eng_b_data  <= bus.req_b[winner*DW +: DW];
            bus.eng_a_valid <= 1'b1;
            bus.eng_b_valid <= 1'b1;
            bus.grant_id    <= winner;
            bus.busy        <= 1'b1;
            state           <= StIssue;
          end
        end
        StIssue: begin
          if (bus.eng_a_ready) bus.eng_a_valid <= 1'b0;
          if (bus.eng_b_ready) bus.eng_b_valid <= 1'b0;
          if (a_done && b_done) begin
            bus.eng_gcd_ready <= 1'b1;
            state             <= StWait;
          end
        end
        StWait: begin
          if (bus.eng_gcd_valid) begin
            bus.rsp_data      <= bus.eng_gcd_data;
            bus.eng_gcd_ready <= 1'b0;
            bus.rsp_valid     <= NREQ'(1) << bus.grant_id;
            state             <= StResp;
          end
        end
        StResp: begin
          if (rsp_hs) begin
            bus.rsp_valid <= '0;
            bus.busy      <= 1'b0;
            ptr           <= (bus.grant_id == GW'(NREQ - 1)) ? '0 : bus.grant_id + 1'b1;
            state         <= StIdle;
          end
        end
      endcase
    end
  end

`ifdef GCD_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.op_count <= '0;
    end else if (state == StResp && rsp_hs && bus.op_count != {CW{1'b1}}) begin
      bus.op_count <= bus.op_count + 1'b1;
    end
  end
`else
  assign bus.op_count = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Bench for gcd_rr_scheduler: vector table, randomized ops and reset-in-flight, checked
// against a reference built from plain arithmetic gcd and a round-robin pick function.
module tb_gcd_rr_scheduler;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREQ = 4;
  localparam int unsigned CW   = 16;
  localparam int          NV   = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gcd_rr_scheduler_if #(.DW(DW), .NREQ(NREQ), .CW(CW)) bus ();

  gcd_rr_scheduler #(.DW(DW), .NREQ(NREQ), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit                         rst;
    logic [NREQ-1:0]            valid;
    logic [NREQ-1:0][DW-1:0]    a;
    logic [NREQ-1:0][DW-1:0]    b;
    int                         ad, bd, rd, hold, n;
    logic [3:0][7:0]            g;
    logic [3:0][DW-1:0]         r;
  } vec_t;

  vec_t vt[NV];

  int checks = 0;
  int errors = 0;

  // Reference state
  bit              model_idle = 1'b1;
  bit              in_resp    = 1'b0;
  bit              issue_chk  = 1'b0;
  bit              rsp_rand   = 1'b0;
  int              exp_ptr    = 0;
  int              exp_grant  = 0;
  int              last_grant = 0;
  int              clr        = -1;
  int              exp_ops    = 0;
  int              hold_cfg   = 0;
  int              hold_cnt   = 0;
  int              a_delay    = 0;
  int              b_delay    = 0;
  int              r_delay    = 0;
  logic [NREQ-1:0] new_valid  = '0;
  logic [DW-1:0]   exp_a, exp_b, exp_res;
  int              glog[$];
  logic [DW-1:0]   dlog[$];

  // Engine stand-in state
  bit            eng_delivered;
  bit            e_active, e_a_hs, e_b_hs, e_r_hs, e_a_done, e_b_done;
  int            e_aw, e_bw, e_rw;
  logic [DW-1:0] e_ca, e_cb;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] gcd_ref(logic [DW-1:0] x, logic [DW-1:0] y);
    logic [DW-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int rr_pick(int p, logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic eng_clear();
    e_active = 0; e_a_hs = 0; e_b_hs = 0; e_r_hs = 0; e_a_done = 0; e_b_done = 0;
    e_aw = 0; e_bw = 0; e_rw = 0;
    bus.eng_a_ready   = 1'b0;
    bus.eng_b_ready   = 1'b0;
    bus.eng_gcd_valid = 1'b0;
    bus.eng_gcd_data  = 32'hdead_beef;
  endtask

  // Engine: accepts A/B after programmable delays, returns gcd after r_delay.
  initial begin
    eng_clear();
    eng_delivered = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        eng_clear();
        eng_delivered = 0;
        continue;
      end
      if (e_a_hs) begin e_a_hs = 0; e_a_done = 1; bus.eng_a_ready = 1'b0; end
      if (e_b_hs) begin e_b_hs = 0; e_b_done = 1; bus.eng_b_ready = 1'b0; end
      if (e_r_hs) begin eng_clear(); eng_delivered = 1; end
      if (!e_active && (bus.eng_a_valid || bus.eng_b_valid)) e_active = 1;
      if (e_active) begin
        chk("eng_a_valid", bus.eng_a_valid, !e_a_done);
        chk("eng_b_valid", bus.eng_b_valid, !e_b_done);
        chk("eng_gcd_ready", bus.eng_gcd_ready, e_a_done && e_b_done);
        if (!e_a_done) chk("eng_a_data", bus.eng_a_data, exp_a);
        if (!e_b_done) chk("eng_b_data", bus.eng_b_data, exp_b);
        if (!e_a_done && !e_a_hs) begin
          if (e_aw >= a_delay) begin bus.eng_a_ready = 1'b1; e_a_hs = 1; e_ca = bus.eng_a_data; end
          else e_aw++;
        end
        if (!e_b_done && !e_b_hs) begin
          if (e_bw >= b_delay) begin bus.eng_b_ready = 1'b1; e_b_hs = 1; e_cb = bus.eng_b_data; end
          else e_bw++;
        end
        if (e_a_done && e_b_done) begin
          if (!bus.eng_gcd_valid) begin
            if (e_rw >= r_delay) begin
              bus.eng_gcd_valid = 1'b1;
              bus.eng_gcd_data  = gcd_ref(e_ca, e_cb);
            end else e_rw++;
          end
          if (bus.eng_gcd_valid && bus.eng_gcd_ready) e_r_hs = 1;
        end
      end
    end
  end

  // One cycle of requester behaviour plus every per-cycle comparison.
  task automatic step();
    logic [NREQ-1:0] exp_rr;
    logic [NREQ-1:0] exp_rv;
    int w;
    @(negedge clk);
    if (clr >= 0) begin bus.req_valid[clr] = 1'b0; clr = -1; end
    bus.req_valid = bus.req_valid | new_valid;
    new_valid = '0;
    #1;
    if (eng_delivered) begin in_resp = 1; eng_delivered = 0; end
    w = rr_pick(exp_ptr, bus.req_valid);
    exp_rr = '0;
    if (model_idle && w >= 0) exp_rr[w] = 1'b1;
    exp_rv = '0;
    if (in_resp) exp_rv[exp_grant] = 1'b1;
    chk("req_ready", bus.req_ready, exp_rr);
    chk("busy", bus.busy, !model_idle);
    chk("grant_id", bus.grant_id, last_grant);
    chk("op_count", bus.op_count, exp_ops);
    chk("rsp_valid", bus.rsp_valid, exp_rv);
    if (issue_chk) begin
      chk("issue_valids", {bus.eng_a_valid, bus.eng_b_valid}, 2'b11);
      issue_chk = 0;
    end
    if (exp_rr != 0) begin
      model_idle = 0;
      exp_grant  = w;
      last_grant = w;
      exp_a      = bus.req_a[w*DW +: DW];
      exp_b      = bus.req_b[w*DW +: DW];
      exp_res    = gcd_ref(exp_a, exp_b);
      clr        = w;
      issue_chk  = 1;
      hold_cnt   = 0;
    end
    if (in_resp) begin
      chk("rsp_data", bus.rsp_data, exp_res);
      if (rsp_rand) bus.rsp_ready = NREQ'($urandom);
      else if (hold_cnt < hold_cfg) begin bus.rsp_ready = '0; hold_cnt++; end
      else bus.rsp_ready = '1;
      if (bus.rsp_ready[exp_grant]) begin
        in_resp    = 0;
        model_idle = 1;
        exp_ptr    = (exp_grant + 1) % NREQ;
`ifdef GCD_SCHED_PERF_EN
        if (exp_ops < (1 << CW) - 1) exp_ops++;
`endif
        glog.push_back(exp_grant);
        dlog.push_back(bus.rsp_data);
      end
    end else begin
      bus.rsp_ready = rsp_rand ? NREQ'($urandom) : '1;
    end
  endtask

  task automatic collect(input int n, input int maxc);
    int start;
    int c;
    start = glog.size();
    c = 0;
    while (glog.size() - start < n && c < maxc) begin
      step();
      c++;
    end
    chk("completions", glog.size() - start, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_eng_valids", {bus.eng_a_valid, bus.eng_b_valid, bus.eng_gcd_ready}, 0);
    chk("rst_eng_data", {bus.eng_a_data, bus.eng_b_data}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_op_count", bus.op_count, 0);
    model_idle = 1; in_resp = 0; issue_chk = 0; exp_ptr = 0; last_grant = 0;
    clr = -1; exp_ops = 0; new_valid = '0; eng_delivered = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_vec(int i, bit rst, int ad, int bd, int rd, int hold);
    vt[i].rst = rst; vt[i].ad = ad; vt[i].bd = bd; vt[i].rd = rd; vt[i].hold = hold;
    vt[i].valid = '0; vt[i].a = '0; vt[i].b = '0; vt[i].n = 0; vt[i].g = '0; vt[i].r = '0;
  endtask

  // Ops are listed in their expected grant order.
  task automatic add_op(int i, int req, logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] res);
    vt[i].valid[req] = 1'b1;
    vt[i].a[req] = a;
    vt[i].b[req] = b;
    vt[i].g[vt[i].n] = 8'(req);
    vt[i].r[vt[i].n] = res;
    vt[i].n++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int c;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '1;

    set_vec(0, 1, 0, 0, 0, 0);
    add_op(0, 0, 48, 18, 6);
    set_vec(1, 1, 1, 1, 2, 0);
    add_op(1, 0, 12, 8, 4);  add_op(1, 1, 0, 24, 24);
    add_op(1, 2, 17, 5, 1);  add_op(1, 3, 9, 9, 9);
    set_vec(2, 0, 0, 0, 0, 0);
    add_op(2, 0, 30, 12, 6); add_op(2, 3, 21, 14, 7);
    set_vec(3, 0, 0, 2, 1, 0);
    add_op(3, 0, 1000, 250, 250);
    set_vec(4, 0, 0, 0, 0, 10);
    add_op(4, 1, 100, 75, 25); add_op(4, 2, 7, 0, 7);
    set_vec(5, 0, 3, 1, 4, 0);
    add_op(5, 3, 35, 64, 1); add_op(5, 2, 1071, 462, 21);

    do_reset();

    for (int i = 0; i < NV; i++) begin
      if (vt[i].rst) do_reset();
      a_delay = vt[i].ad; b_delay = vt[i].bd; r_delay = vt[i].rd;
      hold_cfg = vt[i].hold; rsp_rand = 0;
      bus.req_a = vt[i].a;
      bus.req_b = vt[i].b;
      new_valid = vt[i].valid;
      st = glog.size();
      collect(vt[i].n, 400);
      for (int k = 0; k < vt[i].n; k++) begin
        if (st + k < glog.size()) begin
          chk($sformatf("vec%0d_grant%0d", i, k), glog[st + k], vt[i].g[k]);
          chk($sformatf("vec%0d_data%0d", i, k), dlog[st + k], vt[i].r[k]);
        end
      end
    end

    hold_cfg = 0;
    for (int it = 0; it < 40; it++) begin
      logic [NREQ-1:0] v;
      int f;
      v = NREQ'($urandom_range(1, 15));
      for (int k = 0; k < NREQ; k++) begin
        f = $urandom_range(1, 50);
        bus.req_a[k*DW +: DW] = DW'(f * $urandom_range(0, 200));
        bus.req_b[k*DW +: DW] = DW'(f * $urandom_range(0, 200));
      end
      a_delay = $urandom_range(0, 3);
      b_delay = $urandom_range(0, 3);
      r_delay = $urandom_range(0, 5);
      rsp_rand = (it % 2) == 1;
      new_valid = v;
      collect($countones(v), 2000);
    end

    // Move the pointer to 2, abandon an op in WAIT by reset, then expect 0 before 3.
    rsp_rand = 0; a_delay = 0; b_delay = 0; r_delay = 0;
    bus.req_a[1*DW +: DW] = 14; bus.req_b[1*DW +: DW] = 21;
    new_valid = 4'b0010;
    collect(1, 200);
    r_delay = 40;
    bus.req_a[2*DW +: DW] = 60; bus.req_b[2*DW +: DW] = 84;
    new_valid = 4'b0100;
    c = 0;
    while (bus.eng_gcd_ready !== 1'b1 && c < 50) begin step(); c++; end
    chk("reached_wait", bus.eng_gcd_ready, 1);
    do_reset();
    r_delay = 0;
    bus.req_a[0*DW +: DW] = 18; bus.req_b[0*DW +: DW] = 27;
    bus.req_a[3*DW +: DW] = 50; bus.req_b[3*DW +: DW] = 20;
    new_valid = 4'b1001;
    st = glog.size();
    collect(2, 200);
    if (glog.size() >= st + 2) begin
      chk("post_rst_grant0", glog[st], 0);
      chk("post_rst_data0", dlog[st], 9);
      chk("post_rst_grant1", glog[st + 1], 3);
      chk("post_rst_data1", dlog[st + 1], 10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
